axi_mem_responder: RTL and testbench

// Single-beat AXI-lite style memory responder: the downstream target for the cache's master
// (m_*) port. Accepts independent read and write transactions, stores DEPTH 32-bit words,

---
 rtl/cache_util_pkg.sv | 20 ++
 rtl/axi_mem_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_util_pkg.sv
// Shared response codes and FSM state encodings for the cache
// subsystem and its backing-store memory responder.
package cache_util_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_RESP
   } mem_wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } mem_rd_state_t;

endpackage

// File: rtl/axi_mem_responder.sv
// Single-beat AXI-lite memory responder with programmable read and
// write latency; used as the L2/DRAM backing store behind the cache.
module axi_mem_responder
   import cache_util_pkg::*;
#(
   parameter int                            C_AXI_ADDR_WIDTH = 32,
   parameter int                            C_AXI_DATA_WIDTH = 32,
   parameter int                            DEPTH            = 1024,
   parameter logic [C_AXI_ADDR_WIDTH-1:0]   BASE_ADDR        = '0,
   parameter int                            RD_LATENCY       = 2,
   parameter int                            WR_LATENCY       = 2
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   s_mem_axi_awaddr,
   input  logic                          s_mem_axi_awvalid,
   output logic                          s_mem_axi_awready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   s_mem_axi_wdata,
   input  logic                          s_mem_axi_wvalid,
   output logic                          s_mem_axi_wready,
   output logic [1:0]                    s_mem_axi_bresp,
   output logic                          s_mem_axi_bvalid,
   input  logic                          s_mem_axi_bready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   s_mem_axi_araddr,
   input  logic                          s_mem_axi_arvalid,
   output logic                          s_mem_axi_arready,
   output logic [C_AXI_DATA_WIDTH-1:0]   s_mem_axi_rdata,
   output logic [1:0]                    s_mem_axi_rresp,
   output logic                          s_mem_axi_rvalid,
   input  logic                          s_mem_axi_rready
);

   localparam int AW = C_AXI_ADDR_WIDTH;
   localparam int DW = C_AXI_DATA_WIDTH;
   localparam int IW = $clog2(DEPTH);
   localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH*4);
   localparam logic [3:0] WL = 4'(WR_LATENCY);
   localparam logic [3:0] RL = 4'(RD_LATENCY);

   // Offset wraps modulo 2^AW; the explicit below-base test keeps
   // a wrapped offset from aliasing back into the valid window.
   function automatic logic dec_err(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a - BASE_ADDR;
      return (a < BASE_ADDR) || ({1'b0, off} >= LIMIT) || (a[1:0] != 2'b00);
   endfunction

   function automatic logic [IW-1:0] dec_idx(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a - BASE_ADDR;
      return off[2 +: IW];
   endfunction

   logic [DW-1:0] mem_q [DEPTH];

   mem_wr_state_t wr_st_q, wr_st_d;
   logic          aw_have_q, aw_have_d, w_have_q, w_have_d;
   logic [AW-1:0] awaddr_q, awaddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic          awready_q, awready_d, wready_q, wready_d;
   logic          bvalid_q, bvalid_d;
   logic [1:0]    bresp_q, bresp_d;

   mem_rd_state_t rd_st_q, rd_st_d;
   logic [AW-1:0] araddr_q, araddr_d;
   logic [3:0]    rcnt_q, rcnt_d;
   logic          arready_q, arready_d;
   logic          rvalid_q, rvalid_d;
   logic [1:0]    rresp_q, rresp_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          w_done, werr, commit;
   logic [IW-1:0] widx;
   logic          r_done, rerr;
   logic [IW-1:0] ridx;

   always_comb begin
      wr_st_d   = wr_st_q;
      aw_have_d = aw_have_q;
      w_have_d  = w_have_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wcnt_d    = wcnt_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      w_done    = 1'b0;
      unique case (wr_st_q)
         W_IDLE: begin
            if (s_mem_axi_awvalid && awready_q) begin
               aw_have_d = 1'b1;
               awaddr_d  = s_mem_axi_awaddr;
            end
            if (s_mem_axi_wvalid && wready_q) begin
               w_have_d = 1'b1;
               wdata_d  = s_mem_axi_wdata;
            end
            if (aw_have_d && w_have_d) begin
               wcnt_d = '0;
               if (WL == 4'd0) w_done = 1'b1;
               else            wr_st_d = W_WAIT;
            end
         end
         W_WAIT: begin
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q == WL - 4'd1) w_done = 1'b1;
         end
         W_RESP: begin
            if (s_mem_axi_bready) begin
               bvalid_d  = 1'b0;
               aw_have_d = 1'b0;
               w_have_d  = 1'b0;
               wr_st_d   = W_IDLE;
            end
         end
         default: wr_st_d = W_IDLE;
      endcase
      werr   = dec_err(awaddr_d);
      widx   = dec_idx(awaddr_d);
      commit = w_done && !werr;
      if (w_done) begin
         wr_st_d  = W_RESP;
         bvalid_d = 1'b1;
         bresp_d  = werr ? RESP_SLVERR : RESP_OKAY;
      end
      awready_d = (wr_st_d == W_IDLE) && !aw_have_d;
      wready_d  = (wr_st_d == W_IDLE) && !w_have_d;
   end

   always_comb begin
      rd_st_d  = rd_st_q;
      araddr_d = araddr_q;
      rcnt_d   = rcnt_q;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      r_done   = 1'b0;
      unique case (rd_st_q)
         R_IDLE: begin
            if (s_mem_axi_arvalid && arready_q) begin
               araddr_d = s_mem_axi_araddr;
               rcnt_d   = '0;
               if (RL == 4'd0) r_done = 1'b1;
               else            rd_st_d = R_WAIT;
            end
         end
         R_WAIT: begin
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q == RL - 4'd1) r_done = 1'b1;
         end
         R_DATA: begin
            if (s_mem_axi_rready) begin
               rvalid_d = 1'b0;
               rd_st_d  = R_IDLE;
            end
         end
         default: rd_st_d = R_IDLE;
      endcase
      rerr = dec_err(araddr_d);
      ridx = dec_idx(araddr_d);
      // A commit landing on the same edge as the sample is forwarded.
      if (r_done) begin
         rd_st_d  = R_DATA;
         rvalid_d = 1'b1;
         rresp_d  = rerr ? RESP_SLVERR : RESP_OKAY;
         if (rerr)
            rdata_d = '0;
         else if (commit && widx == ridx)
            rdata_d = wdata_d;
         else
            rdata_d = mem_q[ridx];
      end
      arready_d = (rd_st_d == R_IDLE);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_st_q   <= W_IDLE;
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wcnt_q    <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rd_st_q   <= R_IDLE;
         araddr_q  <= '0;
         rcnt_q    <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_st_q   <= wr_st_d;
         aw_have_q <= aw_have_d;
         w_have_q  <= w_have_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wcnt_q    <= wcnt_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rd_st_q   <= rd_st_d;
         araddr_q  <= araddr_d;
         rcnt_q    <= rcnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         if (commit) mem_q[widx] <= wdata_d;
      end
   end

   assign s_mem_axi_awready = awready_q;
   assign s_mem_axi_wready  = wready_q;
   assign s_mem_axi_bvalid  = bvalid_q;
   assign s_mem_axi_bresp   = bresp_q;
   assign s_mem_axi_arready = arready_q;
   assign s_mem_axi_rvalid  = rvalid_q;
   assign s_mem_axi_rresp   = rresp_q;
   assign s_mem_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus pushes expected
// B/R responses, a negedge monitor pops and compares them.
module tb_axi_mem_responder;
   import cache_util_pkg::*;

   localparam int          LAT  = 2;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;

   always #5 aclk = ~aclk;

   axi_mem_responder #(
      .C_AXI_ADDR_WIDTH(32),
      .C_AXI_DATA_WIDTH(32),
      .DEPTH(1024),
      .BASE_ADDR(BASE),
      .RD_LATENCY(LAT),
      .WR_LATENCY(LAT)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .s_mem_axi_awaddr(awaddr),
      .s_mem_axi_awvalid(awvalid),
      .s_mem_axi_awready(awready),
      .s_mem_axi_wdata(wdata),
      .s_mem_axi_wvalid(wvalid),
      .s_mem_axi_wready(wready),
      .s_mem_axi_bresp(bresp),
      .s_mem_axi_bvalid(bvalid),
      .s_mem_axi_bready(bready),
      .s_mem_axi_araddr(araddr),
      .s_mem_axi_arvalid(arvalid),
      .s_mem_axi_arready(arready),
      .s_mem_axi_rdata(rdata),
      .s_mem_axi_rresp(rresp),
      .s_mem_axi_rvalid(rvalid),
      .s_mem_axi_rready(rready)
   );

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int nvec = 0;
   int nbad = 0;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  r;
   } rexp_t;

   rexp_t      rq[$];
   logic [1:0] bq[$];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endfunction

   logic        b_hold = 1'b0;
   logic        r_hold = 1'b0;
   logic [1:0]  b_prev = '0;
   logic [1:0]  r_prev_r = '0;
   logic [31:0] r_prev_d = '0;

   always @(negedge aclk) begin
      if (areset) begin
         b_hold = 1'b0;
         r_hold = 1'b0;
      end else begin
         if (b_hold) begin
            chk("bvalid_held", {31'b0, bvalid}, 32'd1);
            chk("bresp_stable", {30'b0, bresp}, {30'b0, b_prev});
         end
         b_hold = 1'b0;
         if (bvalid) begin
            chk("aw_w_blocked", {30'b0, awready, wready}, 32'd0);
            if (bready) begin
               if (bq.size() == 0) begin
                  nvec++;
                  nbad++;
                  $display("FAIL b_unexpected: got bresp %b, want none", bresp);
               end else begin
                  chk("bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
               end
            end else begin
               b_hold = 1'b1;
               b_prev = bresp;
            end
         end
         if (r_hold) begin
            chk("rvalid_held", {31'b0, rvalid}, 32'd1);
            chk("rdata_stable", rdata, r_prev_d);
            chk("rresp_stable", {30'b0, rresp}, {30'b0, r_prev_r});
         end
         r_hold = 1'b0;
         if (rvalid) begin
            chk("ar_blocked", {31'b0, arready}, 32'd0);
            if (rready) begin
               if (rq.size() == 0) begin
                  nvec++;
                  nbad++;
                  $display("FAIL r_unexpected: got rdata %h, want none", rdata);
               end else begin
                  rexp_t e;
                  e = rq.pop_front();
                  chk("rdata", rdata, e.d);
                  chk("rresp", {30'b0, rresp}, {30'b0, e.r});
               end
            end else begin
               r_hold   = 1'b1;
               r_prev_d = rdata;
               r_prev_r = rresp;
            end
         end
      end
   end

   task automatic send_aw(input logic [31:0] a, output int c);
      int n = 0;
      logic hs;
      awaddr  = a;
      awvalid = 1'b1;
      do begin
         @(negedge aclk);
         hs = awready;
         c  = cyc;
         @(posedge aclk);
         #1;
         n++;
      end while (!hs && n < 50);
      awvalid = 1'b0;
      chk("aw_accept", {31'b0, hs}, 32'd1);
   endtask

   task automatic send_w(input logic [31:0] d, output int c);
      int n = 0;
      logic hs;
      wdata  = d;
      wvalid = 1'b1;
      do begin
         @(negedge aclk);
         hs = wready;
         c  = cyc;
         @(posedge aclk);
         #1;
         n++;
      end while (!hs && n < 50);
      wvalid = 1'b0;
      chk("w_accept", {31'b0, hs}, 32'd1);
   endtask

   task automatic send_ar(input logic [31:0] a, output int c);
      int n = 0;
      logic hs;
      araddr  = a;
      arvalid = 1'b1;
      do begin
         @(negedge aclk);
         hs = arready;
         c  = cyc;
         @(posedge aclk);
         #1;
         n++;
      end while (!hs && n < 50);
      arvalid = 1'b0;
      chk("ar_accept", {31'b0, hs}, 32'd1);
   endtask

   task automatic wait_b(input int exp_c);
      int n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (!bvalid && n < 60);
      chk("b_latency", cyc, exp_c);
      if (bready) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic wait_r(input int exp_c);
      int n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (!rvalid && n < 60);
      chk("r_latency", cyc, exp_c);
      if (rready) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] er);
      int ca, cw;
      bq.push_back(er);
      fork
         send_aw(a, ca);
         send_w(d, cw);
      join
      wait_b((ca > cw ? ca : cw) + 1 + LAT);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] er);
      int cr;
      rq.push_back('{d: d, r: er});
      send_ar(a, cr);
      wait_r(cr + 1 + LAT);
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      int ca, cw, cr;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
      chk("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
      chk("rst_resps", {28'b0, bresp, rresp}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      step();
      areset = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      chk("idle_readies", {29'b0, awready, wready, arready}, 32'd7);
      step();

      do_write(32'h1000_0004, 32'hCAFE_BABE, RESP_OKAY);
      do_read(32'h1000_0004, 32'hCAFE_BABE, RESP_OKAY);

      bq.push_back(RESP_OKAY);
      send_w(32'h0BAD_F00D, cw);
      @(negedge aclk);
      chk("wready_drop", {31'b0, wready}, 32'd0);
      chk("awready_wait", {31'b0, awready}, 32'd1);
      step();
      step();
      send_aw(32'h1000_000C, ca);
      chk("aw_after_w", ca - cw, 32'd3);
      wait_b(ca + 1 + LAT);
      do_read(32'h1000_000C, 32'h0BAD_F00D, RESP_OKAY);

      bready = 1'b0;
      bq.push_back(RESP_OKAY);
      fork
         send_aw(32'h1000_0008, ca);
         send_w(32'h1234_5678, cw);
      join
      wait_b(ca + 1 + LAT);
      repeat (5) step();
      bready = 1'b1;
      step();
      rready = 1'b0;
      rq.push_back('{d: 32'h1234_5678, r: RESP_OKAY});
      send_ar(32'h1000_0008, cr);
      wait_r(cr + 1 + LAT);
      repeat (5) step();
      rready = 1'b1;
      step();

      do_read(32'h1000_0006, 32'h0, RESP_SLVERR);
      do_read(32'h1000_0002, 32'h0, RESP_SLVERR);
      do_read(32'h1000_1000, 32'h0, RESP_SLVERR);
      do_read(32'h0FFF_FFFC, 32'h0, RESP_SLVERR);
      do_write(32'h1000_0002, 32'hFFFF_FFFF, RESP_SLVERR);
      do_write(32'h1000_1000, 32'hFFFF_FFFF, RESP_SLVERR);
      do_write(32'h0FFF_FFFC, 32'hFFFF_FFFF, RESP_SLVERR);
      do_read(32'h1000_0000, 32'h0, RESP_OKAY);
      do_read(32'h1000_0FFC, 32'h0, RESP_OKAY);
      do_write(32'h1000_0FFC, 32'hA5A5_A5A5, RESP_OKAY);
      do_read(32'h1000_0FFC, 32'hA5A5_A5A5, RESP_OKAY);

      bq.push_back(RESP_OKAY);
      rq.push_back('{d: 32'h0000_0055, r: RESP_OKAY});
      fork
         send_aw(32'h1000_0010, ca);
         send_w(32'h0000_0055, cw);
         send_ar(32'h1000_0010, cr);
      join
      chk("same_cycle_hs", cr, ca);
      fork
         wait_b(ca + 1 + LAT);
         wait_r(cr + 1 + LAT);
      join

      fork
         send_aw(32'h1000_0020, ca);
         send_w(32'hDEAD_BEEF, cw);
         send_ar(32'h1000_0004, cr);
      join
      areset = 1'b1;
      @(negedge aclk);
      chk("abort_valids", {30'b0, bvalid, rvalid}, 32'd0);
      chk("abort_readies", {29'b0, awready, wready, arready}, 32'd0);
      step();
      areset = 1'b0;
      repeat (10) begin
         @(negedge aclk);
         chk("no_resp_after_rst", {30'b0, bvalid, rvalid}, 32'd0);
      end
      step();
      do_read(32'h1000_0020, 32'h0, RESP_OKAY);
      do_read(32'h1000_0004, 32'h0, RESP_OKAY);

      repeat (3) step();
      chk("bq_empty", bq.size(), 32'd0);
      chk("rq_empty", rq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
